// File: rtl/lcd_mmio_ram_if.sv
// Load/store bus between the CPU datapath and lcd_mmio_ram.
// The master drives the byte address, store data and per-lane byte strobes.
// The slave returns combinational read data.
interface lcd_mmio_ram_if #(
    parameter int N = 32
);
    logic [N-1:0]   addr;
    logic [N-1:0]   write_data;
    logic [N/8-1:0] write_enable;
    logic [N-1:0]   data;

    modport master (output addr, output write_data, output write_enable, input data);
    modport slave  (input addr, input write_data, input write_enable, output data);
endinterface

// File: rtl/lcd_mmio_ram.sv
// Byte-addressable data RAM with a hardware-sequenced LCD strobe window.
// The window is three bytes at LCD_BASE: +0 data, +1 ctrl, +2 trigger.
// A nonzero store to the trigger byte while idle latches data/ctrl and runs
// the sequence setup -> enable pulse -> hold. The trigger byte is then cleared
// so firmware can poll it.
//
// Optional macro LCD_MMIO_RAM_RESET_FILL_EN:
//   - defined: reset fills every byte with 0xAA.
//   - undefined: the RAM array has no reset, so it can map to block RAM, and
//     only the window bytes reset (to 0x00).
module lcd_mmio_ram #(
    parameter int N            = 32,
    parameter int SIZE         = 1024,
    parameter int LCD_BASE     = 0,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 4,
    parameter int HOLD_CYCLES  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    lcd_mmio_ram_if.slave      bus,
    output logic [7:0]         lcd_data,
    output logic [1:0]         lcd_ctrl,
    output logic               lcd_enable,
    output logic               lcd_busy
);
    localparam int LANES = N / 8;
    localparam int AW    = $clog2(SIZE);
    localparam int MAXC  = (SETUP_CYCLES > PULSE_CYCLES)
                         ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                         : ((PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES);
    localparam int CW    = $clog2(MAXC + 1);

    localparam logic [AW-1:0] A_DATA = AW'(LCD_BASE);
    localparam logic [AW-1:0] A_CTRL = AW'(LCD_BASE + 1);
    localparam logic [AW-1:0] A_TRIG = AW'(LCD_BASE + 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    // The counter reloads with count-1 so that it reaches zero on the last cycle of each phase.
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);

`ifdef LCD_MMIO_RAM_RESET_FILL_EN
    localparam logic [7:0] WIN_RST = 8'hAA;
`else
    localparam logic [7:0] WIN_RST = 8'h00;
`endif

    // The RAM array also receives window writes, but reads of the window
    // come from the dedicated registers below. Keeping the array free of
    // special cases allows it to map to block RAM.
    logic [7:0]                 mem [SIZE];
    logic [7:0]                 win_data, win_ctrl, win_trig;
    logic [1:0]                 state;
    logic [CW-1:0]              cnt;
    logic [LANES-1:0][AW-1:0]   lane_addr;
    logic [LANES-1:0][7:0]      lane_rd;
    logic                       wr_data, wr_ctrl, wr_trig;
    logic [7:0]                 nxt_data, nxt_ctrl, nxt_trig;
    logic                       idle, start, done;

    if (AW < N) begin : g_unused
        logic unused_addr_hi;
        assign unused_addr_hi = ^bus.addr[N-1:AW];
    end

    // Per-lane wrapped address and read mux; the window registers shadow the array.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_addr[i] = bus.addr[AW-1:0] + AW'(i);
            if (lane_addr[i] == A_DATA)      lane_rd[i] = win_data;
            else if (lane_addr[i] == A_CTRL) lane_rd[i] = win_ctrl;
            else if (lane_addr[i] == A_TRIG) lane_rd[i] = win_trig;
            else                             lane_rd[i] = mem[lane_addr[i]];
        end
    end

    assign bus.data = lane_rd;

    // Decode which window bytes this access writes and what their new values would be.
    always_comb begin
        wr_data  = 1'b0;
        wr_ctrl  = 1'b0;
        wr_trig  = 1'b0;
        nxt_data = win_data;
        nxt_ctrl = win_ctrl;
        nxt_trig = win_trig;
        for (int i = 0; i < LANES; i++) begin
            if (bus.write_enable[i]) begin
                if (lane_addr[i] == A_DATA) begin
                    wr_data  = 1'b1;
                    nxt_data = bus.write_data[8*i +: 8];
                end
                if (lane_addr[i] == A_CTRL) begin
                    wr_ctrl  = 1'b1;
                    nxt_ctrl = bus.write_data[8*i +: 8];
                end
                if (lane_addr[i] == A_TRIG) begin
                    wr_trig  = 1'b1;
                    nxt_trig = bus.write_data[8*i +: 8];
                end
            end
        end
    end

    assign idle       = (state == S_IDLE);
    assign start      = idle && wr_trig && (nxt_trig != 8'h00);
    assign done       = (state == S_HOLD) && (cnt == '0);
    assign lcd_busy   = !idle;
    assign lcd_enable = (state == S_PULSE);

    // Byte-lane stores into the RAM array.
`ifdef LCD_MMIO_RAM_RESET_FILL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < SIZE; j++) mem[j] <= 8'hAA;
        end else begin
            for (int i = 0; i < LANES; i++)
                if (bus.write_enable[i]) mem[lane_addr[i]] <= bus.write_data[8*i +: 8];
        end
    end
`else
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++)
            if (bus.write_enable[i]) mem[lane_addr[i]] <= bus.write_data[8*i +: 8];
    end
`endif

    // Window bytes: data/ctrl are always writable; the trigger byte accepts
    // writes only while idle. The end-of-sequence clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_data <= WIN_RST;
            win_ctrl <= WIN_RST;
            win_trig <= WIN_RST;
        end else begin
            if (wr_data) win_data <= nxt_data;
            if (wr_ctrl) win_ctrl <= nxt_ctrl;
            if (done)                win_trig <= 8'h00;
            else if (wr_trig && idle) win_trig <= nxt_trig;
        end
    end

    // Latch the LCD data/ctrl outputs at trigger. Same-access data/ctrl writes are included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcd_data <= 8'h00;
            lcd_ctrl <= 2'b00;
        end else if (start) begin
            lcd_data <= nxt_data;
            lcd_ctrl <= nxt_ctrl[1:0];
        end
    end

    // Strobe sequencer: each phase lasts (reload value + 1) cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state <= S_SETUP;
                    cnt   <= SETUP_LD;
                end
                S_SETUP: if (cnt == '0) begin
                    state <= S_PULSE;
                    cnt   <= PULSE_LD;
                end else cnt <= cnt - 1'b1;
                S_PULSE: if (cnt == '0) begin
                    state <= S_HOLD;
                    cnt   <= HOLD_LD;
                end else cnt <= cnt - 1'b1;
                S_HOLD: if (cnt == '0) begin
                    state <= S_IDLE;
                end else cnt <= cnt - 1'b1;
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_mmio_ram.sv
// Self-checking bench for lcd_mmio_ram.
// It uses a vector table, hand-written strobe sequences and random traffic.
// The random traffic is checked against a cycle-count reference model.
module tb_lcd_mmio_ram;
    localparam int SIZE = 64;
    localparam int BASE = 0;
    localparam int S    = 1;
    localparam int P    = 4;
    localparam int H    = 1;
    localparam int TOT  = S + P + H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] lcd_data;
    logic [1:0] lcd_ctrl;
    logic       lcd_enable, lcd_busy;

    lcd_mmio_ram_if #(.N(32)) bus ();

    lcd_mmio_ram #(
        .N(32), .SIZE(SIZE), .LCD_BASE(BASE),
        .SETUP_CYCLES(S), .PULSE_CYCLES(P), .HOLD_CYCLES(H)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .lcd_data(lcd_data), .lcd_ctrl(lcd_ctrl),
        .lcd_enable(lcd_enable), .lcd_busy(lcd_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: byte array plus the cycle number of the active trigger.
    logic [7:0] m_mem [SIZE];
    bit         m_known [SIZE];
    bit         m_active;
    int         m_trig;
    int         cyc = 0;
    logic [7:0] m_ld;
    logic [1:0] m_lc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < SIZE; j++) begin
`ifdef LCD_MMIO_RAM_RESET_FILL_EN
            m_mem[j] = 8'hAA; m_known[j] = 1'b1;
`else
            m_mem[j] = 8'h00; m_known[j] = 1'b0;
`endif
        end
        for (int j = 0; j < 3; j++) begin
`ifdef LCD_MMIO_RAM_RESET_FILL_EN
            m_mem[BASE+j] = 8'hAA;
`else
            m_mem[BASE+j] = 8'h00;
`endif
            m_known[BASE+j] = 1'b1;
        end
        m_active = 1'b0;
        m_trig   = 0;
        m_ld     = 8'h00;
        m_lc     = 2'b00;
    endtask

    task automatic model_edge(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we);
        bit busy_before, trig_w;
        int ad;
        logic [7:0] cb;
        cyc++;
        busy_before = m_active && (cyc <= m_trig + TOT);
        trig_w = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                ad = int'((a + 32'(i)) & 32'(SIZE - 1));
                if (!(ad == BASE + 2 && busy_before)) begin
                    m_mem[ad]   = wd[8*i +: 8];
                    m_known[ad] = 1'b1;
                    if (ad == BASE + 2) trig_w = 1'b1;
                end
            end
        end
        if (m_active && cyc == m_trig + TOT) begin
            m_mem[BASE+2] = 8'h00;
            m_active = 1'b0;
        end
        if (!busy_before && trig_w && m_mem[BASE+2] != 8'h00) begin
            m_active = 1'b1;
            m_trig   = cyc;
            m_ld     = m_mem[BASE];
            cb       = m_mem[BASE+1];
            m_lc     = cb[1:0];
        end
    endtask

    task automatic check_all();
        logic [31:0] ed, mk;
        int ad, dt;
        ed = '0; mk = '0;
        for (int i = 0; i < 4; i++) begin
            ad = int'((bus.addr + 32'(i)) & 32'(SIZE - 1));
            if (m_known[ad]) begin
                ed[8*i +: 8] = m_mem[ad];
                mk[8*i +: 8] = 8'hFF;
            end
        end
        dt = cyc - m_trig;
        chk("rdata", bus.data & mk, ed & mk);
        chk("busy", 32'(lcd_busy), 32'(m_active));
        chk("enable", 32'(lcd_enable), 32'(m_active && dt >= S && dt < S + P));
        chk("lcd_data", 32'(lcd_data), 32'(m_ld));
        chk("lcd_ctrl", 32'(lcd_ctrl), 32'(m_lc));
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we);
        bus.addr = a; bus.write_data = wd; bus.write_enable = we;
        @(posedge clk);
        model_edge(a, wd, we);
        #1;
        bus.write_enable = 4'b0000;
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(bus.addr, 32'h0, 4'b0000);
    endtask

    task automatic peek(input logic [31:0] a);
        bus.addr = a;
        #1;
        check_all();
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  we;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [5];

    initial begin
        vt[0] = '{32'(SIZE - 2), 32'h11223344, 4'b1111, 32'h11223344};
        vt[1] = '{32'(SIZE - 2), 32'hAABBCCDD, 4'b0010, 32'h1122CC44};
        vt[2] = '{32'h20, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF};
        vt[3] = '{32'h20, 32'h00000099, 4'b0001, 32'hDEADBE99};
        vt[4] = '{32'h21, 32'h77000000, 4'b1000, 32'h77DEADBE};

        bus.addr = 32'h10; bus.write_data = '0; bus.write_enable = '0;
        model_reset();
        #3;
        chk("rst_enable", 32'(lcd_enable), 32'h0);
        chk("rst_busy", 32'(lcd_busy), 32'h0);
        chk("rst_lcd_data", 32'(lcd_data), 32'h0);
        chk("rst_lcd_ctrl", 32'(lcd_ctrl), 32'h0);
        @(negedge clk); rst_n = 1'b1;
`ifdef LCD_MMIO_RAM_RESET_FILL_EN
        #1; chk("rst_fill", bus.data, 32'hAAAAAAAA);
`else
        bus.addr = 32'(BASE); #1;
        chk("rst_window", bus.data & 32'h00FFFFFF, 32'h0);
`endif

        // Byte lanes and wrap-around.
        for (int i = 0; i < 5; i++) begin
            step(vt[i].a, vt[i].wd, vt[i].we);
            chk("vec_rd", bus.data, vt[i].exp);
        end
        peek(32'h0);

        // Default strobe with the trigger at edge k.
        step(32'(BASE), 32'h41, 4'b0001);
        step(32'(BASE + 1), 32'h02, 4'b0001);
        step(32'(BASE + 2), 32'h01, 4'b0001);
        chk("strobe_data", 32'(lcd_data), 32'h41);
        chk("strobe_ctrl", 32'(lcd_ctrl), 32'h2);
        chk("strobe_busy", 32'(lcd_busy), 32'h1);
        for (int j = 1; j <= 7; j++) begin
            idle(1);
            chk("strobe_en", 32'(lcd_enable), 32'(j >= 1 && j <= 4));
            if (j == 5) chk("strobe_busy_hold", 32'(lcd_busy), 32'h1);
            if (j == 6) chk("strobe_busy_end", 32'(lcd_busy), 32'h0);
        end
        bus.addr = 32'(BASE + 2); #1;
        chk("trig_cleared", bus.data & 32'hFF, 32'h0);

        // Writes while busy.
        step(32'(BASE + 2), 32'h01, 4'b0001);
        idle(2);
        step(32'(BASE), 32'h55, 4'b0001);
        step(32'(BASE + 2), 32'h07, 4'b0001);
        chk("busy_latch", 32'(lcd_data), 32'h41);
        bus.addr = 32'(BASE); #1;
        chk("busy_mem0", bus.data & 32'h00FF00FF, 32'h00010055);
        begin
            int rises = 0;
            logic prev = lcd_enable;
            for (int j = 0; j < 8; j++) begin
                idle(1);
                if (lcd_enable && !prev) rises++;
                prev = lcd_enable;
            end
            chk("busy_no_repulse", 32'(rises), 32'h0);
        end

        // Reset two cycles into the pulse.
        step(32'(BASE + 2), 32'h01, 4'b0001);
        idle(3);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_enable", 32'(lcd_enable), 32'h0);
        chk("midrst_busy", 32'(lcd_busy), 32'h0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        idle(3);

        // A zero trigger does nothing; a combined store starts the sequence.
        step(32'(BASE + 2), 32'h00, 4'b0001);
        chk("zero_trig_busy", 32'(lcd_busy), 32'h0);
        idle(2);
        step(32'(BASE), 32'h00010341, 4'b1111);
        chk("comb_data", 32'(lcd_data), 32'h41);
        chk("comb_ctrl", 32'(lcd_ctrl), 32'h3);
        chk("comb_busy", 32'(lcd_busy), 32'h1);
        idle(8);

        // Re-trigger collides with the clear, then the next edge is accepted.
        step(32'(BASE + 2), 32'h01, 4'b0001);
        idle(TOT - 1);
        step(32'(BASE + 2), 32'h01, 4'b0001);
        chk("collide_busy", 32'(lcd_busy), 32'h0);
        chk("collide_trig", bus.data & 32'hFF, 32'h0);
        step(32'(BASE + 2), 32'h01, 4'b0001);
        chk("retrig_busy", 32'(lcd_busy), 32'h1);
        idle(8);

        // Random traffic biased toward the window.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, wd;
            logic [3:0]  we;
            if ($urandom_range(0, 2) == 0) a = $urandom;
            else a = 32'(BASE) - 32'd3 + 32'($urandom_range(0, 7));
            wd = $urandom;
            if ($urandom_range(0, 1) == 0) wd[7:0] = {7'd0, wd[0]};
            we = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
            step(a, wd, we);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
